// File: rtl/logic_unit_pkg.sv
// Shared definitions for the round-robin logic-unit arbiter: opcodes and the
// output-slot state encoding.
package logic_unit_pkg;

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_OR   = 2'b11;

  // Output slot: EMPTY means no result held, FULL means res_data is valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Shared bitwise logic unit: NAND / XOR / AND / OR over W bits. Purely
// combinational; the arbiter muxes the winning requester's operands into it.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // Opcode decode into the selected bitwise function.
  always_comb begin
    y = '0;
    case (op)
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit among N requesters. One request
// is accepted per cycle whenever the single-entry result register can take it;
// the result is held under a valid/ready handshake.
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] op,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N-1:0]   gnt,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_data,
  output logic [IW-1:0]  res_id
);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [N-1:0]  mask;
  logic          slot_free;
  logic          accept;
  logic [1:0]    sel_op;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [W-1:0]  unit_y;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    win  = '0;
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr);
    end
    // Unmasked fallback first, masked search overrides it when it finds one.
    for (int i = N - 1; i >= 0; i--) begin
      win = req[i] ? IW'(i) : win;
    end
    for (int i = N - 1; i >= 0; i--) begin
      win = (req[i] && mask[i]) ? IW'(i) : win;
    end
  end

  // The slot can accept when empty or when the held result drains this cycle;
  // rst_n gates gnt so nothing is granted while reset is asserted.
  assign slot_free = (state == ST_EMPTY) || res_ready;
  assign accept    = rst_n && slot_free && (|req);
  assign gnt       = accept ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
  assign res_valid = (state == ST_FULL);

  // Winner's operands feed the single shared logic unit.
  assign sel_op = op[2*int'(win) +: 2];
  assign sel_a  = a[W*int'(win) +: W];
  assign sel_b  = b[W*int'(win) +: W];

  logic_unit #(.W(W)) u_logic_unit (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (unit_y)
  );

  // Output-slot next state: accept fills, drain without accept empties.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: state_nxt = accept ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (accept) begin
          state_nxt = ST_FULL;
        end else if (res_ready) begin
          state_nxt = ST_EMPTY;
        end else begin
          state_nxt = ST_FULL;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Output-slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Result, producer id and priority pointer update only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= '0;
      ptr      <= '0;
    end else if (accept) begin
      res_data <= unit_y;
      res_id   <= win;
      ptr      <= (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end else begin
      res_data <= res_data;
      res_id   <= res_id;
      ptr      <= ptr;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus a
// randomized run, all compared against a queue-free behavioural model.
module tb_logic_unit_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] op;
  logic [N*W-1:0] a;
  logic [N*W-1:0] b;
  logic [N-1:0]   gnt;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [IW-1:0]  res_id;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit         m_full;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;
  logic [3:0] m_last_gnt;

  logic_unit_arbiter #(.W(W), .N(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .a         (a),
    .b         (b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_f(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'd0:    return ~(x & y);
      2'd1:    return x ^ y;
      2'd2:    return x & y;
      default: return x | y;
    endcase
  endfunction

  function automatic int model_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt();
    if (!rst_n) return 4'b0000;
    if (m_full && !res_ready) return 4'b0000;
    if (req == 4'b0000) return 4'b0000;
    return 4'b0001 << model_pick(req, m_ptr);
  endfunction

  task automatic model_reset();
    m_full     = 1'b0;
    m_data     = 8'h00;
    m_id       = 0;
    m_ptr      = 0;
    m_last_gnt = 4'b0000;
  endtask

  task automatic model_edge();
    int w;
    m_last_gnt = 4'b0000;
    if (!rst_n) begin
      model_reset();
    end else if ((!m_full || res_ready) && req != 4'b0000) begin
      w = model_pick(req, m_ptr);
      m_last_gnt[w] = 1'b1;
      m_data = model_f(op[2*w +: 2], a[8*w +: 8], b[8*w +: 8]);
      m_id   = w;
      m_full = 1'b1;
      m_ptr  = (w + 1) % N;
    end else if (m_full && res_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    res_ready = 1'b1;
    op = 8'($urandom);
    a = 32'($urandom);
    b = 32'($urandom);
    model_reset();
    #2;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", res_data); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d exp=0", res_id); end
    tick();
    tick();
    rst_n = 1'b1;
    #2;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0 || res_data !== m_data) begin
      errors++; $display("FAIL reset_first_result got=%b/%0d/%h exp=1/0/%h", res_valid, res_id, res_data, m_data);
    end
  endtask

  task automatic test_opcodes();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'hCF; exp_tab[1] = 8'hCC; exp_tab[2] = 8'h30; exp_tab[3] = 8'hFC;
    req = 4'b0100;
    res_ready = 1'b1;
    a[23:16] = 8'hF0;
    b[23:16] = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      op[5:4] = 2'(k);
      #2;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL op_gnt k=%0d got=%b exp=0100", k, gnt); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== exp_tab[k] || res_id !== 2'd2) begin
        errors++; $display("FAIL op_result k=%0d got=%b/%h/%0d exp=1/%h/2", k, res_valid, res_data, res_id, exp_tab[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      #2;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL fair_gnt k=%0d got=%b exp=%b", k, gnt, exp_g); end
      tick();
      checks++; if (res_id !== 2'(k % 4)) begin errors++; $display("FAIL fair_id k=%0d got=%0d exp=%0d", k, res_id, k % 4); end
    end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    req = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt k=%0d got=%b exp=0000", k, gnt); end
      checks++; if (res_valid !== 1'b1 || res_data !== m_data || res_id !== 2'd0) begin
        errors++; $display("FAIL bp_hold k=%0d got=%b/%h/%0d exp=1/%h/0", k, res_valid, res_data, res_id, m_data);
      end
      tick();
    end
    res_ready = 1'b1;
    #2;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_release_gnt got=%b exp=0010", gnt); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== m_data) begin
      errors++; $display("FAIL bp_release_result got=%b/%0d/%h exp=1/1/%h", res_valid, res_id, res_data, m_data);
    end
  endtask

  task automatic test_priority_hold();
    do_reset();
    res_ready = 1'b1;
    req = 4'b0001;
    tick();
    req = 4'b1001;
    #2;
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL prio_gnt_ptr1 got=%b exp=1000", gnt); end
    tick();
    #2;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL prio_gnt_ptr0 got=%b exp=0001", gnt); end
    tick();
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL prio_id got=%0d exp=0", res_id); end
  endtask

  task automatic test_async_reset();
    res_ready = 1'b1;
    req = 4'b0010;
    tick();
    res_ready = 1'b0;
    req = 4'b0000;
    #2;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", res_valid); end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (res_valid !== 1'b0 || res_data !== 8'h00) begin
      errors++; $display("FAIL arst_drop got=%b/%h exp=0/00", res_valid, res_data);
    end
    #2;
    rst_n = 1'b1;
    req = 4'b1111;
    res_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL arst_next_gnt got=%b exp=0001", gnt); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin
      errors++; $display("FAIL arst_next_result got=%b/%0d exp=1/0", res_valid, res_id);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      // Requesters not yet granted keep their operation; others may issue anew.
      for (int i = 0; i < N; i++) begin
        if (!req[i] || m_last_gnt[i]) begin
          req[i]         = ($urandom_range(0, 2) != 0);
          op[2*i +: 2]   = 2'($urandom);
          a[8*i +: 8]    = 8'($urandom);
          b[8*i +: 8]    = 8'($urandom);
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #2;
      exp_g = model_gnt();
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
      checks++; if (res_valid !== m_full) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, res_valid, m_full); end
      if (m_full) begin
        checks++; if (res_data !== m_data || res_id !== 2'(m_id)) begin
          errors++; $display("FAIL rnd_result c=%0d got=%h/%0d exp=%h/%0d", c, res_data, res_id, m_data, m_id);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_fairness();
    test_backpressure();
    test_priority_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
